// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - shared constants and FSM types for the UART APB initiator
package uart_apb_pkg;

    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_CTRL3  = 5'h14;

    localparam int STAT_TXRDY    = 0;
    localparam int STAT_RXRDY    = 1;
    localparam int STAT_PARITY   = 2;
    localparam int STAT_OVERFLOW = 3;
    localparam int STAT_FRAMING  = 4;

    localparam int ERR_PARITY   = 0;
    localparam int ERR_OVERFLOW = 1;
    localparam int ERR_FRAMING  = 2;
    localparam int ERR_SLVERR   = 3;

    typedef enum logic [2:0] {
        ST_INIT1,
        ST_INIT2,
        ST_INIT3,
        ST_POLL,
        ST_RXRD,
        ST_TXWR
    } state_e;

    typedef struct packed {
        state_e st;
        logic   access;
    } fsm_t;

    function automatic logic [4:0] state_addr(input state_e st);
        case (st)
            ST_INIT1: return ADDR_CTRL1;
            ST_INIT2: return ADDR_CTRL2;
            ST_INIT3: return ADDR_CTRL3;
            ST_POLL:  return ADDR_STATUS;
            ST_RXRD:  return ADDR_RXDATA;
            default:  return ADDR_TXDATA;
        endcase
    endfunction

endpackage

// File: rtl/uart_apb_master.sv
// rtl/uart_apb_master.sv - APB3 initiator bridging byte streams to a polled UART slave
module uart_apb_master
    import uart_apb_pkg::*;
#(
    parameter logic [12:0] BAUD_VALUE     = 13'd0,
    parameter logic [2:0]  BAUD_VAL_FRCTN = 3'd0,
    parameter bit          BIT8           = 1'b1,
    parameter bit          PARITY_EN      = 1'b0,
    parameter bit          ODD_N_EVEN     = 1'b0
) (
    input  logic       PCLK,
    input  logic       PRESET,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       init_done,
    output logic [3:0] err_flags,
    input  logic       err_clr
);

    localparam logic [7:0] CTRL1_VAL = BAUD_VALUE[7:0];
    localparam logic [7:0] CTRL2_VAL = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
    localparam logic [7:0] CTRL3_VAL = {5'b0, BAUD_VAL_FRCTN};

    fsm_t       fsm_q, fsm_d;
    logic       psel_q, psel_d;
    logic       penable_q, penable_d;
    logic       pwrite_q, pwrite_d;
    logic [4:0] paddr_q, paddr_d;
    logic [7:0] pwdata_q, pwdata_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       init_done_q, init_done_d;
    logic [3:0] err_q, err_d;
    state_e     next_st;
    logic       load_setup;

    always_comb begin
        fsm_d       = fsm_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        init_done_d = init_done_q;
        err_d       = err_clr ? 4'b0000 : err_q;
        next_st     = fsm_q.st;
        load_setup  = 1'b0;

        // psel_q low only right after reset: present the pending SETUP of the current state
        if (!psel_q) begin
            load_setup = 1'b1;
        end else if (!fsm_q.access) begin
            fsm_d.access = 1'b1;
            penable_d    = 1'b1;
        end else if (PREADY) begin
            load_setup = 1'b1;
            if (PSLVERR) begin
                err_d[ERR_SLVERR] = 1'b1;
            end
            case (fsm_q.st)
                ST_INIT1: next_st = ST_INIT2;
                ST_INIT2: next_st = ST_INIT3;
                ST_INIT3: begin
                    next_st     = ST_POLL;
                    init_done_d = 1'b1;
                end
                ST_POLL: begin
                    err_d[ERR_FRAMING:ERR_PARITY] = err_d[ERR_FRAMING:ERR_PARITY]
                                                  | PRDATA[STAT_FRAMING:STAT_PARITY];
                    if (PRDATA[STAT_RXRDY] && (!rx_valid_q || rx_ready)) begin
                        next_st = ST_RXRD;
                    end else if (PRDATA[STAT_TXRDY] && tx_valid) begin
                        next_st = ST_TXWR;
                    end else begin
                        next_st = ST_POLL;
                    end
                end
                ST_RXRD: begin
                    rx_data_d  = PRDATA;
                    rx_valid_d = 1'b1;
                    next_st    = ST_POLL;
                end
                ST_TXWR: next_st = ST_POLL;
                default: next_st = ST_INIT1;
            endcase
        end

        if (load_setup) begin
            fsm_d.st     = next_st;
            fsm_d.access = 1'b0;
            psel_d       = 1'b1;
            penable_d    = 1'b0;
            paddr_d      = state_addr(next_st);
            pwrite_d     = (next_st != ST_POLL) && (next_st != ST_RXRD);
            case (next_st)
                ST_INIT1: pwdata_d = CTRL1_VAL;
                ST_INIT2: pwdata_d = CTRL2_VAL;
                ST_INIT3: pwdata_d = CTRL3_VAL;
                ST_TXWR:  pwdata_d = tx_data;
                default:  pwdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            fsm_q       <= '{st: ST_INIT1, access: 1'b0};
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 5'h00;
            pwdata_q    <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 4'b0000;
        end else begin
            fsm_q       <= fsm_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign init_done = init_done_q;
    assign err_flags = err_q;
    // Acceptance is the completing TXWR ACCESS; a reset in that cycle cancels it
    assign tx_ready  = (fsm_q.st == ST_TXWR) & fsm_q.access & PREADY & ~PRESET;

endmodule
